// File: rtl/video_ram_scan_dp.sv
// video_ram_scan_dp: parametrised dual-port video RAM with a raster scan engine.
// Port A is an Avalon-MM slave for the CPU: no waitrequest, byte-enabled writes,
// and reads that return avs_readdata with avs_readdatavalid one cycle later.
// Port B belongs to an internal scan engine (IDLE/RUN/STOP). It reads the frame
// in raster order into a 2-entry buffer, which drives a ready/valid stream:
//   out_data/out_valid/out_ready  pixel words, 1 word per cycle at full rate
//   out_sof                       set with word 0 of a frame
//   out_eol                       set with the last word of each line
//   frame_done                    pulse in the cycle word DEPTH-1 transfers
// Optional macro VRAM_WRITE_FORWARD_EN: forwards a same-cycle port-A write into
// the port-B read of the same address and adds the coll_count output.
// Reset is synchronous and active-high and leaves the memory array untouched.
module video_ram_scan_dp #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned WORDS_PER_LINE = 50,
  parameter int unsigned LINES          = 50,
  parameter string       INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic                avs_chipselect,
  input  logic                avs_write,
  input  logic                avs_read,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  input  logic                scan_enable,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eol,
  output logic                frame_done
`ifdef VRAM_WRITE_FORWARD_EN
  ,
  output logic [15:0]         coll_count
`endif
);

  localparam int unsigned DEPTH = WORDS_PER_LINE * LINES;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(WORDS_PER_LINE);
  localparam int unsigned NB    = DATA_W / 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              last;
  } entry_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port-A decode: out-of-range addresses never touch the array.
  logic          a_in_range;
  logic [AW-1:0] a_idx;
  logic          a_wr_en;
  logic          a_rd;

  always_comb begin
    a_in_range = ({1'b0, avs_address} < (ADDR_W + 1)'(DEPTH));
    a_idx      = AW'(avs_address);
    a_wr_en    = avs_chipselect & avs_write & a_in_range;
    // A write in the same cycle wins; the read is dropped.
    a_rd       = avs_chipselect & avs_read & ~avs_write;
  end

  // Scan engine state.
  state_t        state_q, state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic [CW-1:0] scan_col_q, scan_col_d;
  logic          pend_q, pend_d;
  logic          pend_sof_q, pend_sof_d;
  logic          pend_eol_q, pend_eol_d;
  logic          pend_last_q, pend_last_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  entry_t        e0_q, e0_d, e1_q, e1_d;
  logic [DATA_W-1:0] ram_b_q;

  logic       pop_c;
  logic       b_issue_c;
  logic [1:0] occ_c;
  entry_t     push_e;

`ifdef VRAM_WRITE_FORWARD_EN
  logic        coll_c;
  logic [15:0] coll_cnt_q, coll_cnt_d;
  assign coll_c = a_wr_en & b_issue_c & (a_idx == scan_addr_q);
`endif

  // Memory array: port-A byte writes and the port-B scan read.
  always_ff @(posedge clk) begin
    if (a_wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (avs_byteenable[i]) mem[a_idx][8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
    if (b_issue_c) begin
      ram_b_q <= mem[scan_addr_q];
`ifdef VRAM_WRITE_FORWARD_EN
      if (coll_c) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (avs_byteenable[i]) ram_b_q[8*i +: 8] <= avs_writedata[8*i +: 8];
        end
      end
`endif
    end
  end

  // Port-A read return; out-of-range reads still complete, with zero data.
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= a_rd;
      if (a_rd) rd_data_q <= a_in_range ? mem[a_idx] : '0;
    end
  end

  assign avs_readdata      = rd_data_q;
  assign avs_readdatavalid = rd_valid_q;

  // Next-state logic for the scan FSM, read issue and output buffer.
  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    scan_col_d  = scan_col_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    e0_d        = e0_q;
    e1_d        = e1_q;

    pop_c = v0_q & out_ready;
    // Words held plus the one in flight, after this cycle's pop.
    occ_c = 2'(v0_q) + 2'(v1_q) + 2'(pend_q) - 2'(pop_c);

    unique case (state_q)
      S_RUN:   b_issue_c = (occ_c < 2'd2);
      // Finish the current frame only: scan_addr back at 0 means all issued.
      S_STOP:  b_issue_c = (occ_c < 2'd2) && (scan_addr_q != '0);
      default: b_issue_c = 1'b0;
    endcase

    pend_d      = b_issue_c;
    pend_sof_d  = (scan_addr_q == '0);
    pend_eol_d  = (scan_col_q == LAST_COL);
    pend_last_d = (scan_addr_q == LAST_ADDR);

    if (b_issue_c) begin
      scan_addr_d = (scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + AW'(1);
      scan_col_d  = (scan_col_q == LAST_COL) ? '0 : scan_col_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (scan_enable) begin
          state_d     = S_RUN;
          scan_addr_d = '0;
          scan_col_d  = '0;
        end
      end
      S_RUN: begin
        if (!scan_enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (scan_enable) begin
          state_d = S_RUN;
        end else if ((pop_c && e0_q.last) ||
                     (scan_addr_q == '0 && !pend_q && !v0_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_e.data = ram_b_q;
    push_e.sof  = pend_sof_q;
    push_e.eol  = pend_eol_q;
    push_e.last = pend_last_q;

    // Pop shifts slot 1 forward, then the returning word fills the first hole.
    if (pop_c) begin
      v0_d = v1_q;
      e0_d = e1_q;
      v1_d = 1'b0;
    end
    if (pend_q) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        e0_d = push_e;
      end else begin
        v1_d = 1'b1;
        e1_d = push_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      scan_addr_q <= '0;
      scan_col_q  <= '0;
      pend_q      <= 1'b0;
      pend_sof_q  <= 1'b0;
      pend_eol_q  <= 1'b0;
      pend_last_q <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      e0_q        <= '0;
      e1_q        <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      scan_col_q  <= scan_col_d;
      pend_q      <= pend_d;
      pend_sof_q  <= pend_sof_d;
      pend_eol_q  <= pend_eol_d;
      pend_last_q <= pend_last_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
    end
  end

  assign out_valid  = v0_q;
  assign out_data   = e0_q.data;
  assign out_sof    = e0_q.sof;
  assign out_eol    = e0_q.eol;
  // Marks the transfer itself, so it follows out_ready within the cycle.
  assign frame_done = pop_c & e0_q.last & ~reset;

`ifdef VRAM_WRITE_FORWARD_EN
  // Saturating count of same-address write/scan-read collisions.
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_c && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) coll_cnt_q <= 16'd0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign coll_count = coll_cnt_q;
`endif

endmodule

// File: tb/tb_video_ram_scan_dp.sv
// Bench for video_ram_scan_dp: CPU port against a word-array model, and the
// scan stream against the expected raster sequence of that model.
module tb_video_ram_scan_dp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int WPL    = 50;
  localparam int LINES  = 50;
  localparam int DEPTH  = WPL * LINES;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] avs_address;
  logic [3:0]        avs_byteenable;
  logic              avs_chipselect;
  logic              avs_write;
  logic              avs_read;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              scan_enable;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;
  logic              frame_done;
`ifdef VRAM_WRITE_FORWARD_EN
  logic [15:0]       coll_count;
`endif

  logic fixed_ready = 1'b0;
  logic rnd_ready   = 1'b0;
  logic rand_ready  = 1'b0;
  assign out_ready = rand_ready ? rnd_ready : fixed_ready;

  video_ram_scan_dp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_chipselect(avs_chipselect), .avs_write(avs_write), .avs_read(avs_read),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .scan_enable(scan_enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
`ifdef VRAM_WRITE_FORWARD_EN
    , .coll_count(coll_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 2) != 0);
  end

  // Stream monitor: expected word k is exp_mem[k], markers from its position.
  bit          mon_en = 1'b0;
  bit          chk_bubble = 1'b0;
  bit          first_seen = 1'b0;
  bit          prev_stall = 1'b0;
  bit          saw_fd = 1'b0;
  int          exp_k = 0;
  int          words_seen = 0;
  logic [31:0] prev_data;
  logic        prev_sof, prev_eol;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
      first_seen = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_sof", 64'(out_sof), 64'(prev_sof));
        check("hold_eol", 64'(out_eol), 64'(prev_eol));
      end
      if (chk_bubble && first_seen) check("no_bubble", 64'(out_valid), 64'(1));
      if (out_valid && out_ready) begin
        check("word_data", 64'(out_data), 64'(exp_mem[exp_k]));
        check("word_sof", 64'(out_sof), 64'(exp_k == 0));
        check("word_eol", 64'(out_eol), 64'((exp_k % WPL) == WPL - 1));
        check("word_frame_done", 64'(frame_done), 64'(exp_k == DEPTH - 1));
        if (exp_k == DEPTH - 1) saw_fd = 1'b1;
        exp_k = (exp_k + 1) % DEPTH;
        words_seen++;
        if (chk_bubble) first_seen = 1'b1;
      end else begin
        check("frame_done_quiet", 64'(frame_done), 64'(0));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sof   = out_sof;
      prev_eol   = out_eol;
    end
  end

  task automatic cpu_write(input int addr, input logic [3:0] be, input logic [31:0] data);
    avs_address    = ADDR_W'(addr);
    avs_byteenable = be;
    avs_writedata  = data;
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_read       = 1'b0;
    if (addr < DEPTH) begin
      for (int b = 0; b < 4; b++) if (be[b]) exp_mem[addr][8*b +: 8] = data[8*b +: 8];
    end
    @(posedge clk); #1;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic cpu_read_check(input int addr, input string tag);
    logic [31:0] exp;
    exp = (addr < DEPTH) ? exp_mem[addr] : 32'h0;
    avs_address    = ADDR_W'(addr);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    @(posedge clk); #1;
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    check({tag, "_rdv"}, 64'(avs_readdatavalid), 64'(1));
    check(tag, 64'(avs_readdata), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_rdv_off"}, 64'(avs_readdatavalid), 64'(0));
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int target;
    int c;
    target = words_seen + n;
    c = 0;
    while (words_seen < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(tag, 64'(words_seen >= target), 64'(1));
  endtask

  task automatic wait_k(input int k, input int budget, input string tag);
    int c;
    c = 0;
    while (exp_k != k && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(tag, 64'(exp_k), 64'(k));
  endtask

  initial begin
    int a;
    int c;
    logic [3:0] be;
    logic [31:0] d;

    reset = 1'b1;
    avs_address = '0; avs_byteenable = '0; avs_chipselect = 1'b0;
    avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    scan_enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_readdatavalid", 64'(avs_readdatavalid), 64'(0));
    check("rst_readdata", 64'(avs_readdata), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_sof", 64'(out_sof), 64'(0));
    check("rst_out_eol", 64'(out_eol), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
`ifdef VRAM_WRITE_FORWARD_EN
    check("rst_coll_count", 64'(coll_count), 64'(0));
`endif

    // Byte-masked write followed by a read on the next cycle.
    cpu_write(5, 4'b1111, 32'hDEADBEEF);
    cpu_write(5, 4'b0001, 32'h000000AA);
    cpu_read_check(5, "rd_merge");
    check("rd_merge_const", 64'(avs_readdata), 64'(32'hDEADBEAA));

    // Read and write together: write lands, no read return.
    avs_address = ADDR_W'(7); avs_byteenable = 4'hF; avs_writedata = 32'h11223344;
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b1;
    exp_mem[7] = 32'h11223344;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    check("rw_same_rdv", 64'(avs_readdatavalid), 64'(0));
    cpu_read_check(7, "rw_same_data");

    // Address boundaries.
    cpu_write(DEPTH - 1, 4'hF, 32'h0BADCAFE);
    cpu_read_check(DEPTH - 1, "rd_last_addr");
    cpu_write(DEPTH, 4'hF, 32'hCAFEF00D);
    cpu_read_check(DEPTH, "rd_oob_depth");
    cpu_read_check(4095, "rd_oob_top");
    cpu_read_check(0, "rd_addr0");

    // Random CPU traffic, mostly in range.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) a = int'($urandom_range(0, DEPTH - 1));
      else                          a = int'($urandom_range(DEPTH, 4095));
      be = 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 1) == 0) cpu_write(a, be, d);
      else                           cpu_read_check(a, "rd_random");
    end

    // Preload word i = i.
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 4'hF, 32'(i));

    // Full-rate scan across a frame boundary.
    exp_k = 0;
    words_seen = 0;
    saw_fd = 1'b0;
    fixed_ready = 1'b1;
    chk_bubble = 1'b1;
    mon_en = 1'b1;
    scan_enable = 1'b1;
    wait_words(DEPTH + 10, DEPTH + 50, "full_scan_words");
    check("full_scan_frame_done", 64'(saw_fd), 64'(1));
    chk_bubble = 1'b0;

    // Random backpressure.
    rand_ready = 1'b1;
    wait_words(3000, 20000, "backpressure_words");
    rand_ready = 1'b0;

    // Stop mid-frame: stream runs to the frame end, then goes quiet.
    wait_k(1000, 6000, "stop_reach_1000");
    scan_enable = 1'b0;
    saw_fd = 1'b0;
    c = 0;
    while (!saw_fd && c < 3000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("stop_frame_end", 64'(saw_fd), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      check("stop_quiet", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
    end
    check("stop_next_k", 64'(exp_k), 64'(0));
    scan_enable = 1'b1;
    wait_words(60, 200, "restart_words");

    // Reset mid-frame.
    wait_k(700, 6000, "reset_reach_700");
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_sof", 64'(out_sof), 64'(0));
    check("midrst_rdv", 64'(avs_readdatavalid), 64'(0));
    reset = 1'b0;
    exp_k = 0;
    mon_en = 1'b1;
    wait_words(200, 400, "post_reset_words");
    cpu_read_check(0, "mem_keep_0");
    cpu_read_check(700, "mem_keep_700");
    cpu_read_check(DEPTH - 1, "mem_keep_last");

`ifdef VRAM_WRITE_FORWARD_EN
    // Write to the address the scan reads in the same cycle.
    mon_en = 1'b0;
    scan_enable = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fixed_ready = 1'b0;
    scan_enable = 1'b1;
    @(posedge clk); #1;
    cpu_write(0, 4'hF, 32'h12345678);
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("fwd_valid", 64'(out_valid), 64'(1));
    check("fwd_data", 64'(out_data), 64'(32'h12345678));
    check("fwd_sof", 64'(out_sof), 64'(1));
    check("fwd_coll_count", 64'(coll_count), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
